// File: rtl/tile_pkg.sv
// Shared types and constants for the Magic Tiles scoring stage.
package tile_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned STAT_W = 8;

  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd15;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 4'd13;
  localparam logic [NOTE_W-1:0] NOTE_MAX  = 4'd12;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

  // True for a playable note code (1..12).
  function automatic logic is_note(input logic [NOTE_W-1:0] n);
    return (n >= 4'd1) && (n <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Free-running beat counter with synchronous clear; strobes on the last cycle of each beat.
module beat_timer #(
  parameter int unsigned BEAT_CYCLES = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic enable,
  output logic beat_end_c
);

  localparam int unsigned CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign beat_end_c = enable && (count == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (clear || beat_end_c) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tile_judge.sv
// Magic Tiles scoring stage: walks the song ROM one tile per beat and judges
// keypad presses, keeping score, combo and miss statistics for one player.
module tile_judge
  import tile_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 50_000_000,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned SCORE_W     = 12,
  parameter int unsigned COMBO_BONUS = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic [NOTE_W-1:0]  note_in,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [NOTE_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]  expected_note,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [STAT_W-1:0]  combo,
  output logic [STAT_W-1:0]  max_combo,
  output logic [STAT_W-1:0]  miss_count,
  output logic               playing,
  output logic               game_over
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state, state_d;
  logic [NOTE_W-1:0]   note_prev, exp_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                judged, judged_d;
  logic                hit_c, miss_c, clr_stats_c, timer_clr_c, timer_en_c, beat_end_c;
  logic                press_c, note_tile_c, judge_c;
  logic [SCORE_W:0]    score_sum_c;
  logic [SCORE_W-1:0]  score_hit_c;
  logic [STAT_W-1:0]   combo_inc_c;

  beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_timer (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .clear      (timer_clr_c),
    .enable     (timer_en_c),
    .beat_end_c (beat_end_c)
  );

  // A press is a new note code; holding a key does not retrigger.
  assign press_c     = is_note(note_in) && (note_in != note_prev);
  assign note_tile_c = is_note(expected_note);
  assign judge_c     = (state == PLAY) && press_c && note_tile_c && !judged;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d     = state;
    addr_d      = rom_addr;
    exp_d       = expected_note;
    judged_d    = judged;
    hit_c       = 1'b0;
    miss_c      = 1'b0;
    clr_stats_c = 1'b0;
    timer_clr_c = 1'b1;
    timer_en_c  = 1'b0;
    case (state)
      IDLE, DONE: begin
        exp_d = NOTE_REST;
        if (start) begin
          state_d     = FETCH;
          addr_d      = '0;
          clr_stats_c = 1'b1;
        end
      end
      FETCH: begin
        judged_d = 1'b0;
        if (rom_data == NOTE_END) begin
          state_d = DONE;
          exp_d   = NOTE_REST;
        end else begin
          state_d = PLAY;
          exp_d   = rom_data;
        end
      end
      PLAY: begin
        timer_clr_c = 1'b0;
        timer_en_c  = 1'b1;
        if (judge_c) begin
          judged_d = 1'b1;
          hit_c    = (note_in == expected_note);
          miss_c   = (note_in != expected_note);
        end
        // A press on the final cycle wins over the timeout.
        if (beat_end_c) begin
          if (note_tile_c && !judged && !judge_c) miss_c = 1'b1;
          exp_d = NOTE_REST;
          if (rom_addr == ADDR_LAST) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            addr_d  = rom_addr + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      note_prev     <= NOTE_NONE;
      judged        <= 1'b0;
      rom_addr      <= '0;
      expected_note <= NOTE_REST;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      playing       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      note_prev     <= note_in;
      judged        <= judged_d;
      rom_addr      <= addr_d;
      expected_note <= exp_d;
      hit_pulse     <= hit_c;
      miss_pulse    <= miss_c;
      playing       <= (state_d == FETCH) || (state_d == PLAY);
      game_over     <= (state_d == DONE);
    end
  end

  // Bonus is decided on the combo value before this hit is counted.
  always_comb begin
    score_sum_c = {1'b0, score} +
                  ((combo >= STAT_W'(COMBO_BONUS)) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
    score_hit_c = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
    combo_inc_c = (combo == '1) ? combo : combo + STAT_W'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
      miss_count <= '0;
    end else if (clr_stats_c) begin
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
      miss_count <= '0;
    end else if (hit_c) begin
      score <= score_hit_c;
      combo <= combo_inc_c;
      if (combo_inc_c > max_combo) max_combo <= combo_inc_c;
    end else if (miss_c) begin
      combo <= '0;
      if (miss_count != '1) miss_count <= miss_count + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_tile_judge.sv
// Self-checking bench for tile_judge: table of songs/press scripts with a
// per-event scoreboard, plus hand-written restart-ignore and async-reset sequences.
module tb_tile_judge;
  import tile_pkg::*;

  localparam int unsigned BEAT  = 20;
  localparam int unsigned AW    = 3;
  localparam int unsigned SW    = 12;
  localparam int unsigned BONUS = 2;
  localparam int TILE_T = BEAT + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    note_in = 4'd15;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_data;
  logic [3:0]    expected_note;
  logic          hit_pulse, miss_pulse, playing, game_over;
  logic [SW-1:0] score;
  logic [7:0]    combo, max_combo, miss_count;

  logic [3:0] rom_mem [8];
  assign rom_data = rom_mem[rom_addr];

  tile_judge #(.BEAT_CYCLES(BEAT), .ADDR_W(AW), .SCORE_W(SW), .COMBO_BONUS(BONUS)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .start         (start),
    .note_in       (note_in),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .expected_note (expected_note),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .score         (score),
    .combo         (combo),
    .max_combo     (max_combo),
    .miss_count    (miss_count),
    .playing       (playing),
    .game_over     (game_over)
  );

  always #5 sys_clk = ~sys_clk;

  typedef logic [7:0][3:0] nib8_t;
  typedef logic [7:0][4:0] cyc8_t;

  typedef struct packed {
    nib8_t       rom;
    nib8_t       n1;
    cyc8_t       c1;
    nib8_t       n2;
    cyc8_t       c2;
    logic [4:0]  hold;
    logic [11:0] e_score;
    logic [7:0]  e_combo;
    logic [7:0]  e_max;
    logic [7:0]  e_miss;
  } vec_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        hit;
    logic [31:0] score;
    logic [31:0] combo;
    logic [31:0] mx;
    logic [31:0] misses;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  ev_t  sb_q[$];
  vec_t vecs [7];
  int   m_score, m_combo, m_max, m_miss;

  function automatic nib8_t n8(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
    nib8_t r;
    r[0] = 4'(a0); r[1] = 4'(a1); r[2] = 4'(a2); r[3] = 4'(a3);
    r[4] = 4'(a4); r[5] = 4'(a5); r[6] = 4'(a6); r[7] = 4'(a7);
    return r;
  endfunction

  function automatic cyc8_t c8(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
    cyc8_t r;
    r[0] = 5'(a0); r[1] = 5'(a1); r[2] = 5'(a2); r[3] = 5'(a3);
    r[4] = 5'(a4); r[5] = 5'(a5); r[6] = 5'(a6); r[7] = 5'(a7);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_expected_note"}, 32'(expected_note), 0);
    chk({tag, "_hit_pulse"}, 32'(hit_pulse), 0);
    chk({tag, "_miss_pulse"}, 32'(miss_pulse), 0);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_combo"}, 32'(combo), 0);
    chk({tag, "_max_combo"}, 32'(max_combo), 0);
    chk({tag, "_miss_count"}, 32'(miss_count), 0);
    chk({tag, "_playing"}, 32'(playing), 0);
    chk({tag, "_game_over"}, 32'(game_over), 0);
  endtask

  // Reference scoring for one judged tile; queues the pulse expected at cycle cyc.
  task automatic push_event(input int cyc, input logic hit);
    ev_t e;
    if (hit) begin
      m_score = m_score + ((m_combo >= int'(BONUS)) ? 2 : 1);
      if (m_score > 4095) m_score = 4095;
      if (m_combo < 255) m_combo++;
      if (m_combo > m_max) m_max = m_combo;
    end else begin
      m_combo = 0;
      if (m_miss < 255) m_miss++;
    end
    e.cyc = 32'(cyc); e.hit = hit; e.score = 32'(m_score);
    e.combo = 32'(m_combo); e.mx = 32'(m_max); e.misses = 32'(m_miss);
    sb_q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int ntiles, done_i, hold_left, k, c;
    logic in_play, judged, press;
    logic [3:0] cur, drv, prev, tile;
    ev_t e;
    string t;
    t = $sformatf("v%0d", vi);
    ntiles = 8;
    for (int j = 7; j >= 0; j--) if (v.rom[j] == NOTE_END) ntiles = j;
    done_i = (ntiles < 8) ? TILE_T * ntiles + 1 : TILE_T * 8;
    for (int j = 0; j < 8; j++) rom_mem[j] = v.rom[j];
    m_score = 0; m_combo = 0; m_max = 0; m_miss = 0;
    judged = 1'b0; prev = 4'd15; cur = 4'd15; hold_left = 0;
    sb_q.delete();
    note_in = 4'd15;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    for (int i = 0; i <= done_i + 1; i++) begin
      if (i >= 1) begin k = (i - 1) / TILE_T; c = (i - 1) % TILE_T; end
      else begin k = 0; c = TILE_T; end
      in_play = (c < int'(BEAT)) && (k < ntiles);
      if (hit_pulse || miss_pulse) begin
        chk({t, "_pulse_exclusive"}, 32'(hit_pulse && miss_pulse), 0);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_unexpected_pulse: cycle %0d hit=%0b miss=%0b, none required", t, i, hit_pulse, miss_pulse);
        end else begin
          e = sb_q.pop_front();
          chk({t, "_ev_cycle"}, 32'(i), e.cyc);
          chk({t, "_ev_hit"}, 32'(hit_pulse), 32'(e.hit));
          chk({t, "_ev_score"}, 32'(score), e.score);
          chk({t, "_ev_combo"}, 32'(combo), e.combo);
          chk({t, "_ev_max"}, 32'(max_combo), e.mx);
          chk({t, "_ev_misses"}, 32'(miss_count), e.misses);
        end
      end
      if (in_play && c == 10) begin
        chk({t, "_expected_note"}, 32'(expected_note), 32'(v.rom[k]));
        chk({t, "_rom_addr"}, 32'(rom_addr), 32'(k));
        chk({t, "_playing"}, 32'(playing), 1);
      end
      if (i == done_i - 1) chk({t, "_game_over_early"}, 32'(game_over), 0);
      if (i == done_i) begin
        chk({t, "_game_over"}, 32'(game_over), 1);
        chk({t, "_done_playing"}, 32'(playing), 0);
        chk({t, "_done_expected_note"}, 32'(expected_note), 0);
        chk({t, "_done_rom_addr"}, 32'(rom_addr), 32'((ntiles < 8) ? ntiles : 7));
        chk({t, "_final_score"}, 32'(score), 32'(v.e_score));
        chk({t, "_final_combo"}, 32'(combo), 32'(v.e_combo));
        chk({t, "_final_max_combo"}, 32'(max_combo), 32'(v.e_max));
        chk({t, "_final_miss_count"}, 32'(miss_count), 32'(v.e_miss));
      end
      if (in_play && v.n1[k] != 4'd0 && c == int'(v.c1[k])) begin cur = v.n1[k]; hold_left = int'(v.hold); end
      if (in_play && v.n2[k] != 4'd0 && c == int'(v.c2[k])) begin cur = v.n2[k]; hold_left = int'(v.hold); end
      drv = (hold_left > 0) ? cur : 4'd15;
      if (hold_left > 0) hold_left--;
      note_in = drv;
      if (in_play) begin
        if (c == 0) judged = 1'b0;
        tile  = v.rom[k];
        press = is_note(drv) && (drv != prev);
        if (is_note(tile) && !judged && press) begin
          judged = 1'b1;
          push_event(i + 1, drv == tile);
        end else if (is_note(tile) && !judged && c == int'(BEAT) - 1) begin
          push_event(i + 1, 1'b0);
        end
      end
      prev = drv;
      @(negedge sys_clk);
    end
    chk({t, "_scoreboard_drained"}, 32'(sb_q.size()), 0);
    note_in = 4'd15;
  endtask

  initial begin
    vec_t z;
    z = '0;
    z.hold = 5'd1;
    for (int j = 0; j < 7; j++) vecs[j] = z;
    // Two correct presses, then END.
    vecs[0].rom = n8(5, 7, 13, 0, 0, 0, 0, 0);
    vecs[0].n1 = n8(5, 7, 0, 0, 0, 0, 0, 0); vecs[0].c1 = c8(3, 3, 0, 0, 0, 0, 0, 0);
    {vecs[0].e_score, vecs[0].e_combo, vecs[0].e_max, vecs[0].e_miss} = {12'd2, 8'd2, 8'd2, 8'd0};
    // Repeated note with release between; third hit earns the bonus.
    vecs[1].rom = n8(4, 4, 4, 13, 0, 0, 0, 0);
    vecs[1].n1 = n8(4, 4, 4, 0, 0, 0, 0, 0); vecs[1].c1 = c8(3, 3, 3, 0, 0, 0, 0, 0);
    vecs[1].hold = 5'd2;
    {vecs[1].e_score, vecs[1].e_combo, vecs[1].e_max, vecs[1].e_miss} = {12'd4, 8'd3, 8'd3, 8'd0};
    // Wrong press first, the later correct press is ignored.
    vecs[2].rom = n8(3, 13, 0, 0, 0, 0, 0, 0);
    vecs[2].n1 = n8(6, 0, 0, 0, 0, 0, 0, 0); vecs[2].c1 = c8(3, 0, 0, 0, 0, 0, 0, 0);
    vecs[2].n2 = n8(3, 0, 0, 0, 0, 0, 0, 0); vecs[2].c2 = c8(6, 0, 0, 0, 0, 0, 0, 0);
    {vecs[2].e_score, vecs[2].e_combo, vecs[2].e_max, vecs[2].e_miss} = {12'd0, 8'd0, 8'd0, 8'd1};
    // Timed-out note tile, press during rest tile ignored.
    vecs[3].rom = n8(9, 0, 13, 0, 0, 0, 0, 0);
    vecs[3].n1 = n8(0, 2, 0, 0, 0, 0, 0, 0); vecs[3].c1 = c8(0, 5, 0, 0, 0, 0, 0, 0);
    {vecs[3].e_score, vecs[3].e_combo, vecs[3].e_max, vecs[3].e_miss} = {12'd0, 8'd0, 8'd0, 8'd1};
    // Presses on the last beat cycle, full ROM with no END.
    vecs[4].rom = n8(1, 2, 3, 4, 5, 6, 7, 8);
    vecs[4].n1 = n8(1, 2, 3, 4, 5, 6, 7, 8); vecs[4].c1 = c8(19, 19, 19, 19, 19, 19, 19, 19);
    {vecs[4].e_score, vecs[4].e_combo, vecs[4].e_max, vecs[4].e_miss} = {12'd14, 8'd8, 8'd8, 8'd0};
    // Mixed rest codes 14/15, a wrong press and a hit after a miss.
    vecs[5].rom = n8(2, 14, 12, 15, 11, 13, 0, 0);
    vecs[5].n1 = n8(2, 5, 1, 0, 11, 0, 0, 0); vecs[5].c1 = c8(4, 4, 4, 0, 4, 0, 0, 0);
    {vecs[5].e_score, vecs[5].e_combo, vecs[5].e_max, vecs[5].e_miss} = {12'd2, 8'd1, 8'd1, 8'd1};
    // Key held across the tile boundary does not count for the next tile.
    vecs[6].rom = n8(4, 4, 13, 0, 0, 0, 0, 0);
    vecs[6].n1 = n8(4, 0, 0, 0, 0, 0, 0, 0); vecs[6].c1 = c8(18, 0, 0, 0, 0, 0, 0, 0);
    vecs[6].hold = 5'd5;
    {vecs[6].e_score, vecs[6].e_combo, vecs[6].e_max, vecs[6].e_miss} = {12'd1, 8'd0, 8'd1, 8'd1};

    for (int j = 0; j < 8; j++) rom_mem[j] = 4'd13;
    repeat (3) @(negedge sys_clk);
    chk_all_zero("reset");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk_all_zero("idle");

    for (int vi = 0; vi < 7; vi++) run_vec(vecs[vi], vi);

    // start mid-PLAY is ignored; then asynchronous reset aborts the game.
    rom_mem[0] = 4'd5; rom_mem[1] = 4'd6; rom_mem[2] = 4'd7; rom_mem[3] = 4'd13;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      note_in = (i == 4) ? 4'd5 : 4'd15;
      start = (i == 25);
      @(negedge sys_clk);
    end
    start = 1'b0;
    chk("ign_start_expected_note", 32'(expected_note), 6);
    chk("ign_start_rom_addr", 32'(rom_addr), 1);
    chk("ign_start_score", 32'(score), 1);
    chk("ign_start_combo", 32'(combo), 1);
    chk("ign_start_playing", 32'(playing), 1);
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk_all_zero("post_reset_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
